// File: rtl/apb_pkg.sv
// APB requester shared definitions: FSM state encoding and default bus widths.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 3;
  localparam int unsigned APB_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_reg_master_if.sv
// Command/response and APB bus bundle for apb_reg_master.
// master: the requester block itself; slave: everything around it (local logic + APB slave).
interface apb_reg_master_if
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W = APB_ADDR_W,
  parameter int unsigned DATA_W = APB_DATA_W
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  // Local command / response side
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  // APB side
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [NUM_REGS-1:0] select_reg;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W-1:0]   prdata;
  logic                pready;
  logic                psvlerr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, psvlerr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, select_reg, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, psvlerr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, select_reg, pwdata
  );

endinterface

// File: rtl/apb_addr_decoder.sv
// Register index to one-hot select decode; all-zero when not enabled.
module apb_addr_decoder #(
  parameter int unsigned ADDR_W = 3
) (
  input  logic                     en_i,
  input  logic [ADDR_W-1:0]        addr_i,
  output logic [(2**ADDR_W)-1:0]   sel_o
);

  // One bit set for the addressed register, only while enabled
  always_comb begin
    sel_o = '0;
    if (en_i) begin
      sel_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_reg_master.sv
// APB requester for the 8-entry register slave: turns valid/ready commands into an
// APB SETUP/ACCESS sequence and returns read data / slave error on a one-cycle strobe.
// Optional macro APB_TIMEOUT_EN: abort an ACCESS phase that waits TIMEOUT_CYCLES cycles.
module apb_reg_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W = APB_ADDR_W,
  parameter int unsigned DATA_W = APB_DATA_W
`ifdef APB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input logic              pclk,
  input logic              preset,
  apb_reg_master_if.master bus
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  apb_state_e          state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [NUM_REGS-1:0] select_q, select_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                cmd_ready;
  logic                accept;
  logic [NUM_REGS-1:0] dec_sel;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            timeout;
  assign timeout = (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

  // Ready only in IDLE; forced low while reset is asserted
  assign cmd_ready = (state_q == ST_IDLE) && !preset;
  assign accept    = bus.cmd_valid && cmd_ready;

  // Decoder is enabled only on acceptance, so its output is the select for the new SETUP
  apb_addr_decoder #(
    .ADDR_W (ADDR_W)
  ) u_addr_decoder (
    .en_i   (accept),
    .addr_i (bus.cmd_addr),
    .sel_o  (dec_sel)
  );

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    select_d    = select_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // The APB registers double as the latched command for the whole transfer
        if (accept) begin
          state_d   = ST_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = bus.cmd_write;
          pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
          select_d  = dec_sel;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ST_ACCESS: begin
        if (bus.pready) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwrite_d    = 1'b0;
          pwdata_d    = '0;
          select_d    = '0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
          rsp_err_d   = bus.psvlerr;
        end
`ifdef APB_TIMEOUT_EN
        else if (timeout) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwrite_d    = 1'b0;
          pwdata_d    = '0;
          select_d    = '0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        select_d  = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      select_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      select_q    <= select_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.psel       = psel_q;
  assign bus.penable    = penable_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.select_reg = select_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_apb_reg_master.sv
// Self-checking bench for apb_reg_master: directed cases plus randomized transfers
// checked cycle by cycle against a transaction-level expectation.
module tb_apb_reg_master;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;
`ifdef APB_TIMEOUT_EN
  localparam int TMO = 16;
`endif

  logic pclk = 1'b0;
  logic preset;
  int   n_cmp = 0;
  int   n_err = 0;

  apb_reg_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  apb_reg_master #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus_if)
  );

  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Noise on inputs the DUT must ignore in the current cycle
  task automatic noise_inputs();
    bus_if.pready    = 1'($urandom);
    bus_if.psvlerr   = 1'($urandom);
    bus_if.prdata    = 8'($urandom);
  endtask

  task automatic noise_cmd();
    bus_if.cmd_valid = 1'($urandom);
    bus_if.cmd_write = 1'($urandom);
    bus_if.cmd_addr  = 3'($urandom);
    bus_if.cmd_wdata = 8'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.cmd_valid = 1'b0;
      noise_inputs();
      @(negedge pclk);
      check_eq("idle_psel", bus_if.psel, 0);
      check_eq("idle_penable", bus_if.penable, 0);
      check_eq("idle_sel", bus_if.select_reg, 0);
      check_eq("idle_rsp_valid", bus_if.rsp_valid, 0);
      check_eq("idle_ready", bus_if.cmd_ready, 1);
    end
  endtask

  // One full transfer: issued in the current (idle or response) cycle; returns in the
  // response cycle so a following call models a back-to-back command.
  task automatic xfer(input bit wr, input logic [2:0] a, input logic [7:0] wd,
                      input int waits, input logic [7:0] rd, input bit er);
    bit          timed_out;
    int          n_acc;
    logic [31:0] exp_rd;
    logic [31:0] exp_err;
    logic [31:0] exp_sel;
    logic [31:0] exp_wd;
    bit          last;
    timed_out = 1'b0;
    n_acc     = waits + 1;
    exp_rd    = wr ? 32'd0 : 32'(rd);
    exp_err   = 32'(er);
    exp_sel   = 32'd1 << a;
    exp_wd    = wr ? 32'(wd) : 32'd0;
`ifdef APB_TIMEOUT_EN
    if (waits >= TMO) begin
      timed_out = 1'b1;
      n_acc     = TMO;
      exp_rd    = 32'd0;
      exp_err   = 32'd1;
    end
`endif
    check_eq("accept_ready", bus_if.cmd_ready, 1);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = wr;
    bus_if.cmd_addr  = a;
    bus_if.cmd_wdata = wd;
    noise_inputs();
    @(negedge pclk);
    check_eq("setup_psel", bus_if.psel, 1);
    check_eq("setup_penable", bus_if.penable, 0);
    check_eq("setup_pwrite", bus_if.pwrite, 32'(wr));
    check_eq("setup_pwdata", bus_if.pwdata, exp_wd);
    check_eq("setup_sel", bus_if.select_reg, exp_sel);
    check_eq("setup_ready", bus_if.cmd_ready, 0);
    check_eq("setup_rsp_valid", bus_if.rsp_valid, 0);
    noise_cmd();
    noise_inputs();
    @(negedge pclk);
    for (int i = 0; i < n_acc; i++) begin
      check_eq("acc_psel", bus_if.psel, 1);
      check_eq("acc_penable", bus_if.penable, 1);
      check_eq("acc_pwrite", bus_if.pwrite, 32'(wr));
      check_eq("acc_pwdata", bus_if.pwdata, exp_wd);
      check_eq("acc_sel", bus_if.select_reg, exp_sel);
      check_eq("acc_rsp_valid", bus_if.rsp_valid, 0);
      last = (i == n_acc - 1);
      noise_cmd();
      bus_if.pready  = last && !timed_out;
      bus_if.psvlerr = last ? er : 1'($urandom);
      bus_if.prdata  = last ? rd : 8'($urandom);
      @(negedge pclk);
    end
    check_eq("rsp_valid", bus_if.rsp_valid, 1);
    check_eq("rsp_rdata", bus_if.rsp_rdata, exp_rd);
    check_eq("rsp_err", bus_if.rsp_err, exp_err);
    check_eq("rsp_psel", bus_if.psel, 0);
    check_eq("rsp_penable", bus_if.penable, 0);
    check_eq("rsp_sel", bus_if.select_reg, 0);
    check_eq("rsp_ready", bus_if.cmd_ready, 1);
  endtask

  task automatic reset_mid_access();
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = 1'b0;
    bus_if.cmd_addr  = 3'd6;
    bus_if.cmd_wdata = 8'h00;
    bus_if.pready    = 1'b0;
    @(negedge pclk);
    bus_if.cmd_valid = 1'b0;
    @(negedge pclk);
    check_eq("rst_mid_penable", bus_if.penable, 1);
    bus_if.pready  = 1'b1;
    bus_if.psvlerr = 1'b1;
    bus_if.prdata  = 8'hEE;
    preset         = 1'b1;
    @(negedge pclk);
    check_eq("rst_mid_psel", bus_if.psel, 0);
    check_eq("rst_mid_penable0", bus_if.penable, 0);
    check_eq("rst_mid_sel", bus_if.select_reg, 0);
    check_eq("rst_mid_rsp_valid", bus_if.rsp_valid, 0);
    check_eq("rst_mid_ready", bus_if.cmd_ready, 0);
    preset        = 1'b0;
    bus_if.pready = 1'b0;
    @(negedge pclk);
    check_eq("rst_after_rsp_valid", bus_if.rsp_valid, 0);
    check_eq("rst_after_ready", bus_if.cmd_ready, 1);
    check_eq("rst_after_psel", bus_if.psel, 0);
  endtask

  initial begin
    preset           = 1'b1;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = 1'b1;
    bus_if.cmd_addr  = 3'd2;
    bus_if.cmd_wdata = 8'h11;
    bus_if.prdata    = 8'h00;
    bus_if.pready    = 1'b0;
    bus_if.psvlerr   = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check_eq("rst_psel", bus_if.psel, 0);
      check_eq("rst_penable", bus_if.penable, 0);
      check_eq("rst_pwrite", bus_if.pwrite, 0);
      check_eq("rst_sel", bus_if.select_reg, 0);
      check_eq("rst_pwdata", bus_if.pwdata, 0);
      check_eq("rst_rsp_valid", bus_if.rsp_valid, 0);
      check_eq("rst_rsp_rdata", bus_if.rsp_rdata, 0);
      check_eq("rst_rsp_err", bus_if.rsp_err, 0);
      check_eq("rst_ready", bus_if.cmd_ready, 0);
    end
    preset           = 1'b0;
    bus_if.cmd_valid = 1'b0;
    @(negedge pclk);
    check_eq("post_rst_ready", bus_if.cmd_ready, 1);
    check_eq("post_rst_psel", bus_if.psel, 0);

    // Write with two wait states, read with none
    xfer(1'b1, 3'd3, 8'hA5, 2, 8'h00, 1'b0);
    idle_cycles(1);
    xfer(1'b0, 3'd7, 8'h00, 0, 8'h5C, 1'b0);
    idle_cycles(2);

    // Slave error on a read of register 0, then a back-to-back write
    xfer(1'b0, 3'd0, 8'h00, 0, 8'h3E, 1'b1);
    xfer(1'b1, 3'd5, 8'h3C, 1, 8'h77, 1'b0);
    idle_cycles(1);

    // Long wait: completes normally without the timeout, aborts with it
    xfer(1'b0, 3'd2, 8'h00, 20, 8'h99, 1'b0);
    idle_cycles(1);

    reset_mid_access();

    for (int t = 0; t < 80; t++) begin
      xfer(1'($urandom), 3'($urandom), 8'($urandom), int'($urandom_range(0, 4)),
           8'($urandom), 1'($urandom));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_reg_master.md
Name: apb_reg_master

Overview:
- APB requester stage that sits directly upstream of the 8-entry APB register slave.
- Accepts simple valid/ready read/write commands from the local control logic.
- Runs the APB SETUP/ACCESS sequence and drives the slave's one-hot register select.
- Returns read data and the slave error flag on a one-cycle response strobe.

Parameters:
- ADDR_W, 3, register index width; NUM_REGS = 2**ADDR_W.
- DATA_W, 8, data width of pwdata, prdata and cmd/rsp data.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort; only used with APB_TIMEOUT_EN.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- preset  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  register index.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  error for the completed transfer.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- select_reg  out  NUM_REGS  one-hot register select to the slave.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  slave ready.
- psvlerr  in  1  slave error.

Behaviour:
- Reset (preset=1 sampled at a pclk edge):
  - State goes to IDLE.
  - psel, penable, pwrite, select_reg, pwdata, rsp_valid, rsp_rdata, rsp_err all clear to 0.
  - cmd_ready=0 while preset is high.
  - A reset mid-transfer aborts the transfer with no rsp_valid.
- All APB outputs and rsp_* outputs are registered.
- FSM IDLE -> SETUP -> ACCESS -> IDLE:
  - IDLE: cmd_ready=1, psel=0, penable=0, select_reg=0. On cmd_valid && cmd_ready, latch cmd_write, cmd_addr and cmd_wdata, then go to SETUP.
  - SETUP (exactly 1 cycle): psel=1, penable=0, pwrite = latched write, pwdata = latched data (0 on reads), select_reg = 1 << addr. Next state is ACCESS. cmd_ready=0.
  - ACCESS: psel=1, penable=1, all other APB outputs held stable. Remain in ACCESS while pready=0.
  - ACCESS completion: the cycle pready=1 is sampled. Capture prdata into rsp_rdata (reads only; 0 for writes) and psvlerr into rsp_err. Set rsp_valid=1 for the next cycle and return to IDLE. In that cycle psel=0, penable=0, select_reg=0.
- Back-to-back:
  - cmd_ready=1 in the IDLE cycle that shows rsp_valid=1, so a new command may be accepted in the same cycle.
  - Minimum 3 cycles per transfer with zero wait states.
- select_reg is never nonzero outside SETUP/ACCESS and is always exactly one-hot inside them.
- cmd_valid while cmd_ready=0 is ignored; the requester must hold the command.
- pready and psvlerr are ignored outside ACCESS.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES-1 with pready still 0, the transfer aborts: rsp_valid=1, rsp_err=1, rsp_rdata=0, then IDLE.
  - Counter width is clog2(TIMEOUT_CYCLES).
- Undefined:
  - No counter logic exists.
  - ACCESS waits on pready indefinitely.

Decomposition:
- Package apb_pkg holds:
  - state encoding constants ST_IDLE=2'b00, ST_SETUP=2'b01, ST_ACCESS=2'b10;
  - default ADDR_W and DATA_W.
- Sub-module apb_addr_decoder:
  - Combinational ADDR_W-to-NUM_REGS one-hot decode with an enable input; all-zero when disabled.
  - Its output is registered in apb_reg_master.

Test Plan:
- Reset: hold preset=1 for 3 cycles -> all outputs 0, cmd_ready=0; after release cmd_ready=1 the next cycle.
- Write, addr=3, wdata=0xA5, pready low 2 ACCESS cycles:
  - SETUP shows psel=1, penable=0, select_reg=0x08, pwdata=0xA5, pwrite=1.
  - ACCESS lasts 3 cycles.
  - rsp_valid pulses once with rsp_err=0, rsp_rdata=0.
- Read, addr=7, prdata=0x5C, pready=1 immediately -> select_reg=0x80, pwrite=0; rsp_valid with rsp_rdata=0x5C three cycles after acceptance.
- Error and back-to-back:
  - psvlerr=1 at completion of a read of addr 0 -> rsp_err=1.
  - A second command held valid is accepted in the rsp_valid cycle and issued with no idle gap.
- Reset mid-ACCESS: assert preset during ACCESS -> next cycle psel=0, penable=0, select_reg=0, no rsp_valid.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and pready held 0 -> after 16 ACCESS cycles rsp_valid=1, rsp_err=1, then IDLE.
